// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider (datapath and controller).
package divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Total command cycles per division: one load+shift, then two per quotient bit.
  localparam int unsigned DIV_CYCLES = 1 + 2 * DEFAULT_WIDTH;

  // R-register source select encodings.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_ALU  = 2'b01,
    SEL_LOAD = 2'b10,
    SEL_PASS = 2'b11
  } sel_e;

endpackage

// File: rtl/div_addsub.sv
// WIDTH+1-bit add/subtract ALU: sum = a +/- {0,b}, wrapping; msb is the sign.
module div_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] b,
  input  logic             add,
  output logic [WIDTH:0]   sum,
  output logic             msb
);

  logic [WIDTH:0] b_ext;

  assign b_ext = {1'b0, b};

  // Add when requested, otherwise subtract the zero-extended operand.
  always_comb begin
    sum = add ? (a + b_ext) : (a - b_ext);
    msb = sum[WIDTH];
  end

endmodule

// File: rtl/divider_datapath.sv
// Restoring-divider datapath: divisor, partial remainder and quotient
// registers, ALU sign feedback to the controller, and a result snapshot.
// Optional feature macro: DIV_ZERO_FLAG_EN adds a div_zero output flag.
module divider_datapath
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             load,
  input  logic             add,
  input  logic             shift,
  input  logic             inbit,
  input  logic [1:0]       sel,
  input  logic             valid,
  output logic             sign,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             result_ready
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   alu_out;
  logic [WIDTH:0]   rn;
  logic [WIDTH-1:0] qn;
  logic             add_g;
  logic             inbit_g;
  sel_e             sel_cmd;
  logic             unused_load;

  assign sel_cmd = sel_e'(sel);

  // Don't-care command bits are forced low so an undriven value never lands in state.
  assign add_g   = (sel_cmd == SEL_ALU) & add;
  assign inbit_g = shift & inbit;

  // load duplicates sel==SEL_LOAD; sel is authoritative.
  assign unused_load = load;

  div_addsub #(.WIDTH(WIDTH)) u_alu (
    .a   (r_reg),
    .b   (d_reg),
    .add (add_g),
    .sum (alu_out),
    .msb (sign)
  );

  // Pre-shift value of {R,Q} selected by the controller's sel command.
  always_comb begin
    rn = r_reg;
    qn = q_reg;
    case (sel_cmd)
      SEL_ALU:  rn = alu_out;
      SEL_LOAD: begin
        rn = '0;
        qn = dividend;
      end
      default:  ;
    endcase
  end

  // Working registers: divisor load and the optional left shift of {R,Q}.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_reg <= '0;
      r_reg <= '0;
      q_reg <= '0;
    end else begin
      if (sel_cmd == SEL_LOAD)
        d_reg <= divisor;
      if (shift)
        {r_reg, q_reg} <= {rn[WIDTH-1:0], qn, inbit_g};
      else begin
        r_reg <= rn;
        q_reg <= qn;
      end
    end
  end

  // Result snapshot; the last shift doubled R, so the remainder is R[WIDTH:1].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient     <= '0;
      remainder    <= '0;
      result_ready <= 1'b0;
    end else if (valid) begin
      quotient     <= q_reg;
      remainder    <= r_reg[WIDTH:1];
      result_ready <= 1'b1;
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic dz;

  // Zero-divisor flag tracked per load and snapshotted with the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dz       <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (sel_cmd == SEL_LOAD)
        dz <= (divisor == '0);
      if (valid)
        div_zero <= dz;
    end
  end
`else
  // Without the flag a zero divisor simply yields an all-ones quotient.
`endif

endmodule

// File: tb/tb_divider_datapath.sv
// Self-checking bench for divider_datapath: acts as the controller, steering
// each iteration from a behavioural restoring-division model.
module tb_divider_datapath;
  import divider_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] dividend, divisor;
  logic         load, add, shift, inbit, valid;
  logic [1:0]   sel;
  logic         sign;
  logic [W-1:0] quotient, remainder;
  logic         result_ready;
`ifdef DIV_ZERO_FLAG_EN
  logic         div_zero;
`endif

  int errors = 0;
  int checks = 0;

  divider_datapath #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .dividend     (dividend),
    .divisor      (divisor),
    .load         (load),
    .add          (add),
    .shift        (shift),
    .inbit        (inbit),
    .sel          (sel),
    .valid        (valid),
    .sign         (sign),
    .quotient     (quotient),
    .remainder    (remainder),
    .result_ready (result_ready)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero     (div_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic drive(input sel_e s, input logic ld, input logic ad,
                       input logic sh, input logic ib, input logic vl);
    sel   = s;
    load  = ld;
    add   = ad;
    shift = sh;
    inbit = ib;
    valid = vl;
  endtask

  task automatic cyc(input sel_e s, input logic ld, input logic ad,
                     input logic sh, input logic ib, input logic vl);
    drive(s, ld, ad, sh, ib, vl);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(SEL_HOLD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Controller role: classic restoring division decides each step; DUT sign is checked against it.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit do_valid);
    int unsigned rem;
    logic neg;
    dividend = a;
    divisor  = b;
    cyc(SEL_LOAD, 1'b1, rb(), 1'b1, 1'b0, 1'b0);
    dividend = logic'($urandom_range(0, 255));
    divisor  = logic'($urandom_range(0, 255));
    rem = 0;
    for (int i = W - 1; i >= 0; i--) begin
      rem = rem * 2 + int'(a[i]);
      neg = (rem < int'(b));
      drive(SEL_ALU, 1'b0, 1'b0, 1'b0, rb(), 1'b0);
      #2;
      chk("sign_sub", 32'(sign), 32'(neg));
      @(posedge clk);
      #1;
      if (neg)
        cyc(SEL_ALU, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      else begin
        rem = rem - int'(b);
        cyc(SEL_PASS, 1'b0, rb(), 1'b1, 1'b1, 1'b0);
      end
    end
    if (do_valid)
      cyc(SEL_HOLD, 1'b0, rb(), 1'b0, rb(), 1'b1);
    idle();
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] eq,
                              input logic [W-1:0] er, input logic edz);
    chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(remainder), 32'(er));
    chk({tag, "_ready"}, 32'(result_ready), 32'd1);
`ifdef DIV_ZERO_FLAG_EN
    chk({tag, "_div_zero"}, 32'(div_zero), 32'(edz));
`else
    if (edz === 1'bz) $display("unexpected flag value");
`endif
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    logic [W-1:0] ra, rbv, eq, er;

    vecs.push_back('{8'd100, 8'd7,   8'd14,  8'd2});
    vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0});
    vecs.push_back('{8'd3,   8'd10,  8'd0,   8'd3});
    vecs.push_back('{8'd5,   8'd0,   8'd255, 8'd5});
    vecs.push_back('{8'd6,   8'd3,   8'd2,   8'd0});
    vecs.push_back('{8'd200, 8'd9,   8'd22,  8'd2});
    vecs.push_back('{8'd0,   8'd7,   8'd0,   8'd0});
    vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0});
    vecs.push_back('{8'd254, 8'd255, 8'd0,   8'd254});
    vecs.push_back('{8'd128, 8'd2,   8'd64,  8'd0});

    reset    = 1'b1;
    dividend = '0;
    divisor  = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_ready", 32'(result_ready), 32'd0);
    chk("reset_sign", 32'(sign), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fixed table, including divide-by-zero followed by a normal division.
    foreach (vecs[k]) begin
      v = vecs[k];
      run_div(v.a, v.b, 1'b1);
      check_result("table", v.exp_q, v.exp_r, v.b == '0);
    end

    // Reset partway through 200/9 aborts at once, then a clean rerun.
    dividend = 8'd200;
    divisor  = 8'd9;
    cyc(SEL_LOAD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(SEL_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(SEL_ALU, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(SEL_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(SEL_ALU, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(SEL_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_ready", 32'(result_ready), 32'd0);
    chk("abort_sign", 32'(sign), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk("abort_div_zero", 32'(div_zero), 32'd0);
`endif
    idle();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_div(8'd200, 8'd9, 1'b1);
    check_result("rerun", 8'd22, 8'd2, 1'b0);

    // Snapshot holds across a new division until the next valid.
    run_div(8'd100, 8'd7, 1'b1);
    check_result("hold_first", 8'd14, 8'd2, 1'b0);
    run_div(8'd50, 8'd5, 1'b0);
    check_result("hold_kept", 8'd14, 8'd2, 1'b0);
    cyc(SEL_HOLD, 1'b0, rb(), 1'b0, rb(), 1'b1);
    check_result("hold_new", 8'd10, 8'd0, 1'b0);
    cyc(SEL_HOLD, 1'b0, rb(), 1'b0, rb(), 1'b1);
    idle();
    check_result("recapture", 8'd10, 8'd0, 1'b0);

    // Randomized operands against plain integer division.
    for (int n = 0; n < 40; n++) begin
      ra  = W'($urandom_range(0, 255));
      rbv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      if (rbv == '0) begin
        eq = '1;
        er = ra;
      end else begin
        eq = ra / rbv;
        er = ra % rbv;
      end
      run_div(ra, rbv, 1'b1);
      check_result("random", eq, er, rbv == '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider_datapath.md
Name: divider_datapath

Overview:
- Arithmetic datapath for the restoring divider; it is the responder to `controller`.
- Consumes the controller's `load`/`add`/`shift`/`inbit`/`sel`/`valid` commands and returns `sign`, the combinational MSB of the ALU result, which steers the controller's restore/accept decision.
- Holds the divisor, partial remainder and quotient registers. Presents a result snapshot, captured on `valid`, to the surrounding system.

Parameters:
- WIDTH, 8, operand width; quotient and remainder are WIDTH bits, the partial remainder is WIDTH+1 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- dividend  input  WIDTH  unsigned dividend, sampled when load=1.
- divisor  input  WIDTH  unsigned divisor, sampled when load=1.
- load  input  1  operand load command.
- add  input  1  ALU op: 1 = R+D, 0 = R−D. Meaningful only when sel=01.
- shift  input  1  shift {R,Q} left one place this cycle.
- inbit  input  1  bit entering Q[0] on shift. Meaningful only when shift=1.
- sel  input  2  R-register source select.
- valid  input  1  final iteration complete; capture result.
- sign  output  1  alu_out[WIDTH], combinational.
- quotient  output  WIDTH  captured quotient.
- remainder  output  WIDTH  captured remainder.
- result_ready  output  1  high from the first capture until reset.

Behaviour:
- Registers:
  - D: WIDTH bits, divisor.
  - R: WIDTH+1 bits, partial remainder.
  - Q: WIDTH bits, quotient / dividend bits.
- ALU: alu_out = R ± {0,D}, modulo 2^(WIDTH+1), continuously computed from the registered R and D. sign = alu_out[WIDTH], with zero latency; the controller samples it in the same cycle.
- sel decoding, forming the pre-shift value {Rn,Qn}:
  - 00: hold, Rn=R, Qn=Q.
  - 01: Rn=alu_out, Qn=Q.
  - 10: load, Rn=0, Qn=dividend, and D<=divisor. This is the only sel value that writes D.
  - 11: pass, Rn=R, Qn=Q. Identical to 00 and used in the quotient-bit-1 step.
- Update rules:
  - shift=1: {R,Q} <= {Rn[WIDTH-1:0], Qn, inbit}.
  - shift=0: {R,Q} <= {Rn,Qn}.
- load=1 with sel≠10 is illegal; the datapath obeys sel and ignores load.
- X tolerance: add when sel≠01 and inbit when shift=0 must not reach any register. Gate them so that X on these inputs never propagates.
- Command sequence per iteration, from the controller:
  - load+shift.
  - Subtract step (sel=01, add=0).
  - Then one of:
    - Restore+shift0 (sel=01, add=1, inbit=0) if sign=1.
    - Pass+shift1 (sel=11, inbit=1) if sign=0.
  - Total 1 + 2·WIDTH cycles = 17 for WIDTH=8.
- Final result: quotient = Q, remainder = R[WIDTH:1] (the last shift doubled R).
- Capture: on a clk edge with valid=1, quotient<=Q, remainder<=R[WIDTH:1], result_ready<=1.
  - Outputs hold until the next valid, including across new loads.
  - valid on consecutive cycles re-captures each cycle.
- Divisor zero: no special-casing. Result is quotient = all ones, remainder = dividend.
- Reset values: D=0, R=0, Q=0, quotient=0, remainder=0, result_ready=0.
  - Reset mid-division aborts immediately.
  - The next load starts cleanly.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- When defined:
  - Adds output div_zero (1 bit) and a register dz, set on load when divisor==0 (cleared on load otherwise).
  - div_zero is captured alongside quotient on valid.
  - Reset clears both dz and div_zero.
- When undefined: no port and no register; results follow the all-ones rule above.

Decomposition:
- Shared package divider_pkg holds:
  - WIDTH default.
  - sel encodings SEL_HOLD=2'b00, SEL_ALU=2'b01, SEL_LOAD=2'b10, SEL_PASS=2'b11.
  - Iteration count constant DIV_CYCLES = 1+2·WIDTH.
  - These are shared with `controller`.
- One natural sub-module: div_addsub, the WIDTH+1-bit add/subtract ALU (combinational, returns sum and MSB). Registers and muxing stay in the top level.

Test Plan:
- Drive the exact controller sequence for 100/7 -> after valid, quotient=14, remainder=2, result_ready=1. During the 1st subtract, sign=1.
- 255/1 -> quotient=255, remainder=0. sign=0 on every subtract step.
- 3/10 -> quotient=0, remainder=3. sign=1 on every subtract step.
- 5/0 -> quotient=255, remainder=5. With DIV_ZERO_FLAG_EN, div_zero=1; with 6/3 afterwards, div_zero=0, quotient=2.
- Start 200/9, assert reset at cycle 6 -> all outputs 0 immediately. Then 200/9 completes to quotient=22, remainder=2.
- Capture 100/7, then load 50/5 and run without valid -> outputs hold 14/2 until valid, then read 10/0. Drive add=X and inbit=X where they are don't-care -> no X on any output.
